// File: rtl/spi_xfer_arbiter.sv
// Round-robin sequencer sharing one SPI master core among NREQ requesters.
// Ports: req/req_ss/req_len/req_tx in, tx_taken/rx_*/done/err/busy out, spi_* core register bus.
module spi_xfer_arbiter #(
  parameter int NREQ    = 2,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_ss,
  input  logic [LENW*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0]    req_tx,
  output logic [NREQ-1:0]      tx_taken,
  output logic [7:0]           rx_data,
  output logic [NREQ-1:0]      rx_valid,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic                 busy,
  output logic                 spi_select,
  output logic                 spi_read_n,
  output logic                 spi_write_n,
  output logic [2:0]           spi_mem_addr,
  output logic [15:0]          spi_data_from_cpu,
  input  logic [15:0]          spi_data_to_cpu
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_WR_SS, S_SSO_ON, S_WR_TX,
    S_POLL, S_RD_RX, S_SSO_OFF, S_CLR, S_DONE
  } state_t;

  state_t          st;
  logic [1:0]      ph;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic [LENW-1:0] rem;
  logic [11:0]     tcnt;
  logic            err_f;

  logic [PW-1:0]   pick;
  logic            found;
  logic [15:0]     cur_ss;
  logic [7:0]      cur_tx;
  logic [LENW-1:0] pick_len;
  logic [NREQ-1:0] oh_g;
  logic            bus_st;
  logic            acc_rd;
  logic [2:0]      acc_addr;
  logic [15:0]     acc_data;
  logic            unused;

  assign unused = ^{spi_data_to_cpu[15:8],
                    spi_data_to_cpu[6:5],
                    spi_data_to_cpu[2:0]};

  assign oh_g = NREQ'(1) << gnt;

  // Scan downward so the nearest index above ptr wins.
  always_comb begin
    logic [PW-1:0] j;
    pick  = '0;
    found = 1'b0;
    j     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_ss   = '0;
    cur_tx   = '0;
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == PW'(i)) begin
        cur_ss = req_ss[16*i +: 16];
        cur_tx = req_tx[8*i +: 8];
      end
      if (pick == PW'(i))
        pick_len = req_len[LENW*i +: LENW];
    end
  end

  always_comb begin
    bus_st   = 1'b1;
    acc_rd   = 1'b0;
    acc_addr = 3'd0;
    acc_data = 16'h0000;
    unique case (st)
      S_WR_SS:   begin acc_addr = 3'd5; acc_data = cur_ss; end
      S_SSO_ON:  begin acc_addr = 3'd3; acc_data = 16'h0400; end
      S_WR_TX:   begin acc_addr = 3'd1; acc_data = {8'h00, cur_tx}; end
      S_POLL:    begin acc_addr = 3'd2; acc_rd = 1'b1; end
      S_RD_RX:   begin acc_addr = 3'd0; acc_rd = 1'b1; end
      S_SSO_OFF: begin acc_addr = 3'd3; end
      S_CLR:     begin acc_addr = 3'd2; end
      default:   bus_st = 1'b0;
    endcase
  end

  // Each bus state runs idle -> cycle1 -> cycle2 via ph,
  // so consecutive accesses always get one idle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st                <= S_IDLE;
      ph                <= 2'd0;
      ptr               <= PW'(NREQ - 1);
      gnt               <= '0;
      rem               <= '0;
      tcnt              <= '0;
      err_f             <= 1'b0;
      tx_taken          <= '0;
      rx_data           <= '0;
      rx_valid          <= '0;
      done              <= '0;
      err               <= 1'b0;
      busy              <= 1'b0;
      spi_select        <= 1'b0;
      spi_read_n        <= 1'b1;
      spi_write_n       <= 1'b1;
      spi_mem_addr      <= 3'd0;
      spi_data_from_cpu <= 16'h0000;
    end else begin
      tx_taken <= '0;
      rx_valid <= '0;
      done     <= '0;
      err      <= 1'b0;
      if (st == S_POLL && tcnt != 12'hFFF)
        tcnt <= tcnt + 12'd1;
      if (bus_st) begin
        unique case (ph)
          2'd0: begin
            spi_select        <= 1'b1;
            spi_read_n        <= ~acc_rd;
            spi_write_n       <= acc_rd;
            spi_mem_addr      <= acc_addr;
            spi_data_from_cpu <= acc_data;
            ph                <= 2'd1;
          end
          2'd1: begin
            ph <= 2'd2;
            if (st == S_WR_TX) begin
              tx_taken <= oh_g;
              rem      <= rem - LENW'(1);
            end
          end
          default: begin
            spi_select  <= 1'b0;
            spi_read_n  <= 1'b1;
            spi_write_n <= 1'b1;
            ph          <= 2'd0;
            unique case (st)
              S_WR_SS:  st <= S_SSO_ON;
              S_SSO_ON: st <= S_WR_TX;
              S_WR_TX: begin
                st   <= S_POLL;
                tcnt <= '0;
              end
              S_POLL: begin
                if (spi_data_to_cpu[4] | spi_data_to_cpu[3])
                  err_f <= 1'b1;
                if (spi_data_to_cpu[7]) begin
                  st <= S_RD_RX;
                end else if (tcnt >= 12'(TIMEOUT - 1)) begin
                  err_f <= 1'b1;
                  st    <= S_SSO_OFF;
                end
              end
              S_RD_RX: begin
                rx_data  <= spi_data_to_cpu[7:0];
                rx_valid <= oh_g;
                st <= (rem != '0) ? S_WR_TX : S_SSO_OFF;
              end
              S_SSO_OFF: begin
                if (err_f) begin
                  st <= S_CLR;
                end else begin
                  st   <= S_DONE;
                  done <= oh_g;
                  busy <= 1'b0;
                end
              end
              S_CLR: begin
                st   <= S_DONE;
                done <= oh_g;
                err  <= err_f;
                busy <= 1'b0;
              end
              default: st <= S_IDLE;
            endcase
          end
        endcase
      end else begin
        unique case (st)
          S_IDLE: if (|req) st <= S_ARB;
          S_ARB: begin
            if (found) begin
              gnt   <= pick;
              ptr   <= pick;
              rem   <= pick_len;
              err_f <= 1'b0;
              if (pick_len == '0) begin
                st   <= S_DONE;
                done <= NREQ'(1) << pick;
              end else begin
                st   <= S_WR_SS;
                busy <= 1'b1;
              end
            end else begin
              st <= S_IDLE;
            end
          end
          S_DONE: begin
            st    <= S_IDLE;
            err_f <= 1'b0;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule
